// File: rtl/store_buffer_pkg.sv
// Shared LSU definitions for the store buffer: entry layout, store size encoding
// and default depth.
package store_buffer_pkg;

    localparam int ST_BUF_N_ENTRIES = 8;
    localparam int ST_BUF_ADDR_W    = 32;
    localparam int ST_BUF_DATA_W    = 32;
    localparam int ST_BUF_ROB_W     = 5;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } st_size_e;

    typedef struct packed {
        logic                     valid;
        logic                     committed;
        logic [ST_BUF_ADDR_W-1:0] addr;
        logic [ST_BUF_DATA_W-1:0] data;
        st_size_e                 size;
        logic [ST_BUF_ROB_W-1:0]  rob_id;
    } st_buf_entry_t;

    // Keeps only the bytes that a right-aligned access of this size carries.
    function automatic logic [ST_BUF_DATA_W-1:0] size_data_mask(input logic [1:0] size);
        logic [ST_BUF_DATA_W-1:0] m;
        case (st_size_e'(size))
            SZ_BYTE: m = 32'h0000_00FF;
            SZ_HALF: m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_buffer_byte_mask_gen.sv
// Byte-lane mask of a naturally aligned access: size-derived lanes shifted by
// the low address bits. The reserved size code covers no lanes.
module byte_mask_gen
    import store_buffer_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] offset_i,
    output logic [3:0] mask_o
);

    logic [3:0] base;

    always_comb begin
        case (st_size_e'(size_i))
            SZ_BYTE: base = 4'b0001;
            SZ_HALF: base = 4'b0011;
            SZ_WORD: base = 4'b1111;
            default: base = 4'b0000;
        endcase
        mask_o = base << offset_i;
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: in-order FIFO of issued stores that drain to the D-cache once
// committed, with same-cycle store-to-load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int N_ENTRIES    = ST_BUF_N_ENTRIES,
    parameter int ADDR_WIDTH   = ST_BUF_ADDR_W,
    parameter int DATA_WIDTH   = ST_BUF_DATA_W,
    parameter int ROB_ID_WIDTH = ST_BUF_ROB_W
) (
    input  logic                             clk,
    input  logic                             rst_aL,
    input  logic                             enq_valid,
    output logic                             enq_ready,
    input  logic [ADDR_WIDTH-1:0]            enq_addr,
    input  logic [DATA_WIDTH-1:0]            enq_data,
    input  logic [1:0]                       enq_size,
    input  logic [ROB_ID_WIDTH-1:0]          enq_rob_id,
    input  logic                             commit_valid,
    input  logic [ROB_ID_WIDTH-1:0]          commit_rob_id,
    input  logic                             flush,
    output logic                             dc_req_valid,
    input  logic                             dc_req_ready,
    output logic [ADDR_WIDTH-1:0]            dc_req_addr,
    output logic [DATA_WIDTH-1:0]            dc_req_data,
    output logic [1:0]                       dc_req_size,
    input  logic [ADDR_WIDTH-1:0]            fwd_addr,
    input  logic [1:0]                       fwd_size,
    output logic                             fwd_hit,
    output logic                             fwd_conflict,
    output logic [DATA_WIDTH-1:0]            fwd_data,
    output logic [$clog2(N_ENTRIES+1)-1:0]   count
);

    localparam int IW = $clog2(N_ENTRIES);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(N_ENTRIES + 1);

    st_buf_entry_t   entries_q [N_ENTRIES];
    st_buf_entry_t   entries_d [N_ENTRIES];
    logic [3:0]      mask_q    [N_ENTRIES];
    logic [3:0]      mask_d    [N_ENTRIES];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]   n_comm;
    logic [IW-1:0]   head_idx, tail_idx, fidx;
    logic            full, do_enq, do_pop;
    logic [3:0]      enq_mask, ld_mask, sel_mask;
    logic            sel_found;
    logic [1:0]      sel_off;
    logic [DATA_WIDTH-1:0] sel_data;

    assign head_idx = head_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[PW-1] != tail_q[PW-1]);
    assign count    = CW'(tail_q - head_q);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high. enq_ready depends only on state and flush, never on enq_valid
    // or this cycle's pop; dc_req_* hold steady while dc_req_valid waits on ready.
    assign enq_ready    = ~full & ~flush;
    assign do_enq       = enq_valid & enq_ready;
    assign dc_req_valid = entries_q[head_idx].valid & entries_q[head_idx].committed;
    assign do_pop       = dc_req_valid & dc_req_ready;
    assign dc_req_addr  = entries_q[head_idx].addr & {ADDR_WIDTH{dc_req_valid}};
    assign dc_req_data  = entries_q[head_idx].data & {DATA_WIDTH{dc_req_valid}};
    assign dc_req_size  = entries_q[head_idx].size & {2{dc_req_valid}};

    byte_mask_gen u_enq_mask (
        .size_i   (enq_size),
        .offset_i (enq_addr[1:0]),
        .mask_o   (enq_mask)
    );

    byte_mask_gen u_fwd_mask (
        .size_i   (fwd_size),
        .offset_i (fwd_addr[1:0]),
        .mask_o   (ld_mask)
    );

    // Same-cycle ordering: commit, then pop, then flush (which blocks enqueue).
    always_comb begin
        entries_d = entries_q;
        mask_d    = mask_q;
        head_d    = head_q;
        tail_d    = tail_q;
        n_comm    = '0;
        if (commit_valid) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (entries_q[i].valid && !entries_q[i].committed &&
                    entries_q[i].rob_id == commit_rob_id) begin
                    entries_d[i].committed = 1'b1;
                end
            end
        end
        if (do_pop) begin
            entries_d[head_idx].valid     = 1'b0;
            entries_d[head_idx].committed = 1'b0;
            head_d = head_q + PW'(1);
        end
        if (flush) begin
            // Committed stores form the oldest run, so they start at the new head.
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (entries_d[i].valid && entries_d[i].committed) begin
                    n_comm = n_comm + PW'(1);
                end else begin
                    entries_d[i].valid     = 1'b0;
                    entries_d[i].committed = 1'b0;
                end
            end
            tail_d = head_d + n_comm;
        end else if (do_enq) begin
            entries_d[tail_idx] = '{valid:     1'b1,
                                    committed: 1'b0,
                                    addr:      enq_addr,
                                    data:      enq_data & size_data_mask(enq_size),
                                    size:      st_size_e'(enq_size),
                                    rob_id:    enq_rob_id};
            mask_d[tail_idx] = enq_mask;
            tail_d = tail_q + PW'(1);
        end
    end

    // Walk oldest to youngest so the last overlapping match is the youngest store.
    always_comb begin
        sel_found = 1'b0;
        sel_mask  = '0;
        sel_off   = '0;
        sel_data  = '0;
        fidx      = '0;
        for (int k = 0; k < N_ENTRIES; k++) begin
            fidx = head_idx + IW'(k);
            if (entries_q[fidx].valid &&
                entries_q[fidx].addr[ADDR_WIDTH-1:2] == fwd_addr[ADDR_WIDTH-1:2] &&
                |(mask_q[fidx] & ld_mask)) begin
                sel_found = 1'b1;
                sel_mask  = mask_q[fidx];
                sel_off   = entries_q[fidx].addr[1:0];
                sel_data  = entries_q[fidx].data;
            end
        end
        fwd_hit      = sel_found && ((sel_mask & ld_mask) == ld_mask);
        fwd_conflict = sel_found && !fwd_hit;
        fwd_data     = '0;
        if (fwd_hit) begin
            fwd_data = ((sel_data << {sel_off, 3'b000}) >> {fwd_addr[1:0], 3'b000})
                       & size_data_mask(fwd_size);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                entries_q[i] <= '0;
                mask_q[i]    <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            entries_q <= entries_d;
            mask_q    <= mask_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios and a randomized run compared
// against a program-order queue model of the buffered stores.
module tb_store_buffer;

    localparam int N = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_aL, enq_valid, enq_ready, commit_valid, flush;
    logic [31:0] enq_addr, enq_data, dc_req_addr, dc_req_data, fwd_addr, fwd_data;
    logic [1:0]  enq_size, dc_req_size, fwd_size;
    logic [4:0]  enq_rob_id, commit_rob_id;
    logic        dc_req_valid, dc_req_ready, fwd_hit, fwd_conflict;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [4:0]  rob;
        bit          committed;
    } st_t;

    st_t         mq[$];
    logic [31:0] exp_q[$];

    store_buffer dut (
        .clk           (clk),
        .rst_aL        (rst_aL),
        .enq_valid     (enq_valid),
        .enq_ready     (enq_ready),
        .enq_addr      (enq_addr),
        .enq_data      (enq_data),
        .enq_size      (enq_size),
        .enq_rob_id    (enq_rob_id),
        .commit_valid  (commit_valid),
        .commit_rob_id (commit_rob_id),
        .flush         (flush),
        .dc_req_valid  (dc_req_valid),
        .dc_req_ready  (dc_req_ready),
        .dc_req_addr   (dc_req_addr),
        .dc_req_data   (dc_req_data),
        .dc_req_size   (dc_req_size),
        .fwd_addr      (fwd_addr),
        .fwd_size      (fwd_size),
        .fwd_hit       (fwd_hit),
        .fwd_conflict  (fwd_conflict),
        .fwd_data      (fwd_data),
        .count         (count)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    // Youngest store whose byte range intersects the load decides the result.
    function automatic void model_fwd(input logic [31:0] a, input logic [1:0] sz,
                                      output bit hit, output bit conf, output logic [31:0] d);
        int lo, ln, so, sn;
        hit = 1'b0;
        conf = 1'b0;
        d = '0;
        lo = int'(a[1:0]);
        ln = nbytes(sz);
        if (ln == 0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            so = int'(mq[i].addr[1:0]);
            sn = nbytes(mq[i].size);
            if (mq[i].addr[31:2] == a[31:2] && so < lo + ln && lo < so + sn) begin
                if (so <= lo && lo + ln <= so + sn) begin
                    hit = 1'b1;
                    for (int j = 0; j < ln; j++) d[8*j +: 8] = mq[i].data[8*(lo - so + j) +: 8];
                end else begin
                    conf = 1'b1;
                end
                return;
            end
        end
    endfunction

    // Advance one clock and apply the same events to the model.
    task automatic tick();
        bit  pop_ok, rdy;
        st_t s;
        rdy    = (mq.size() < N) && !flush;
        pop_ok = (mq.size() > 0) && mq[0].committed && dc_req_ready;
        @(posedge clk);
        if (!rst_aL) begin
            mq.delete();
            exp_q.delete();
        end else begin
            if (commit_valid) begin
                foreach (mq[i]) begin
                    if (!mq[i].committed && mq[i].rob == commit_rob_id) begin
                        mq[i].committed = 1'b1;
                        exp_q.push_back(mq[i].data);
                    end
                end
            end
            if (pop_ok) void'(mq.pop_front());
            if (flush) begin
                for (int i = mq.size() - 1; i >= 0; i--) if (!mq[i].committed) mq.delete(i);
            end else if (enq_valid && rdy) begin
                s.addr = enq_addr;
                s.data = enq_data;
                s.size = enq_size;
                s.rob = enq_rob_id;
                s.committed = 1'b0;
                mq.push_back(s);
            end
        end
        @(negedge clk);
    endtask

    task automatic set_enq(input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic [4:0] rob);
        enq_valid = v;
        enq_addr = a;
        enq_data = d;
        enq_size = sz;
        enq_rob_id = rob;
    endtask

    task automatic drain();
        enq_valid = 1'b0;
        commit_valid = 1'b0;
        flush = 1'b0;
        dc_req_ready = 1'b1;
        for (int i = 0; i < 20 && count != 4'd0; i++) tick();
    endtask

    task automatic test_reset();
        rst_aL = 1'b0;
        set_enq(1'b0, '0, '0, 2'd0, '0);
        commit_valid = 1'b0;
        commit_rob_id = '0;
        flush = 1'b0;
        dc_req_ready = 1'b0;
        fwd_addr = '0;
        fwd_size = 2'd0;
        tick();
        tick();
        rst_aL = 1'b1;
        #1;
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got %b exp 1", enq_ready); end
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL reset_dc_valid got %b exp 0", dc_req_valid); end
        checks++; if (dc_req_addr !== 32'd0) begin errors++; $display("FAIL reset_dc_addr got %h exp 0", dc_req_addr); end
        checks++; if (dc_req_data !== 32'd0) begin errors++; $display("FAIL reset_dc_data got %h exp 0", dc_req_data); end
        checks++; if (dc_req_size !== 2'd0) begin errors++; $display("FAIL reset_dc_size got %0d exp 0", dc_req_size); end
        checks++; if (fwd_hit !== 1'b0 || fwd_conflict !== 1'b0) begin errors++; $display("FAIL reset_fwd_flags got %b%b exp 00", fwd_hit, fwd_conflict); end
        checks++; if (fwd_data !== 32'd0) begin errors++; $display("FAIL reset_fwd_data got %h exp 0", fwd_data); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    endtask

    task automatic test_single_store();
        dc_req_ready = 1'b1;
        set_enq(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 5'd3);
        #1;
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL single_enq_ready got %b exp 1", enq_ready); end
        tick();
        enq_valid = 1'b0;
        commit_valid = 1'b1;
        commit_rob_id = 5'd3;
        #1;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", dc_req_valid); end
        tick();
        commit_valid = 1'b0;
        #1;
        checks++; if (dc_req_valid !== 1'b1) begin errors++; $display("FAIL single_dc_valid got %b exp 1", dc_req_valid); end
        checks++; if (dc_req_addr !== 32'h100) begin errors++; $display("FAIL single_dc_addr got %h exp 100", dc_req_addr); end
        checks++; if (dc_req_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_dc_data got %h exp deadbeef", dc_req_data); end
        checks++; if (dc_req_size !== 2'd2) begin errors++; $display("FAIL single_dc_size got %0d exp 2", dc_req_size); end
        tick();
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_drained_count got %0d exp 0", count); end
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL single_drained_valid got %b exp 0", dc_req_valid); end
    endtask

    task automatic test_full_wrap();
        dc_req_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_enq(1'b1, 32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'd2, 5'(10 + i));
            tick();
        end
        enq_valid = 1'b0;
        #1;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_enq_ready got %b exp 0", enq_ready); end
        commit_valid = 1'b1;
        commit_rob_id = 5'd10;
        tick();
        commit_valid = 1'b0;
        dc_req_ready = 1'b1;
        set_enq(1'b1, 32'h440, 32'hC0FFEE00, 2'd2, 5'd18);
        #1;
        checks++; if (dc_req_valid !== 1'b1) begin errors++; $display("FAIL full_head_valid got %b exp 1", dc_req_valid); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle_ready got %b exp 0", enq_ready); end
        tick();
        #1;
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_after_pop_count got %0d exp 7", count); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready got %b exp 1", enq_ready); end
        tick();
        enq_valid = 1'b0;
        fwd_addr = 32'h440;
        fwd_size = 2'd2;
        #1;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL wrap_count got %0d exp 8", count); end
        checks++; if (fwd_hit !== 1'b1) begin errors++; $display("FAIL wrap_fwd_hit got %b exp 1", fwd_hit); end
        checks++; if (fwd_data !== 32'hC0FFEE00) begin errors++; $display("FAIL wrap_fwd_data got %h exp c0ffee00", fwd_data); end
        for (int r = 11; r <= 18; r++) begin
            commit_valid = 1'b1;
            commit_rob_id = 5'(r);
            tick();
        end
        drain();
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_forward();
        logic [31:0] la [7];
        logic [1:0]  ls [7];
        logic        eh [7];
        logic        ec [7];
        logic [31:0] ed [7];
        la = '{32'h200, 32'h201, 32'h203, 32'h202, 32'h200, 32'h204, 32'h200};
        ls = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
        eh = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        ec = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ed = '{32'h0, 32'hAA, 32'h11, 32'h1122, 32'h0, 32'h0, 32'h44};
        dc_req_ready = 1'b0;
        set_enq(1'b1, 32'h200, 32'h11223344, 2'd2, 5'd1);
        tick();
        set_enq(1'b1, 32'h201, 32'hAA, 2'd0, 5'd2);
        tick();
        enq_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            fwd_addr = la[i];
            fwd_size = ls[i];
            #1;
            checks++; if (fwd_hit !== eh[i]) begin errors++; $display("FAIL fwd_hit[%0d] got %b exp %b", i, fwd_hit, eh[i]); end
            checks++; if (fwd_conflict !== ec[i]) begin errors++; $display("FAIL fwd_conflict[%0d] got %b exp %b", i, fwd_conflict, ec[i]); end
            checks++; if (fwd_data !== ed[i]) begin errors++; $display("FAIL fwd_data[%0d] got %h exp %h", i, fwd_data, ed[i]); end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL fwd_flush_count got %0d exp 0", count); end
    endtask

    task automatic test_flush();
        dc_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_enq(1'b1, 32'h500 + 32'(4 * i), 32'h5500 + 32'(i), 2'd2, 5'(1 + i));
            tick();
        end
        enq_valid = 1'b0;
        commit_valid = 1'b1;
        commit_rob_id = 5'd1;
        flush = 1'b1;
        #1;
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_enq got %b exp 0", enq_ready); end
        tick();
        commit_valid = 1'b0;
        flush = 1'b0;
        fwd_addr = 32'h504;
        fwd_size = 2'd2;
        #1;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL flush_count got %0d exp 1", count); end
        checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 32'h500) begin errors++; $display("FAIL flush_head got v=%b a=%h exp v=1 a=500", dc_req_valid, dc_req_addr); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL flush_squashed_fwd got %b exp 0", fwd_hit); end
        dc_req_ready = 1'b1;
        tick();
        #1;
        checks++; if (count !== 4'd0 || dc_req_valid !== 1'b0) begin errors++; $display("FAIL flush_drain got c=%0d v=%b exp c=0 v=0", count, dc_req_valid); end
    endtask

    task automatic test_backpressure();
        dc_req_ready = 1'b0;
        set_enq(1'b1, 32'h602, 32'hBEEF, 2'd1, 5'd5);
        tick();
        set_enq(1'b1, 32'h700, 32'h12345678, 2'd2, 5'd6);
        commit_valid = 1'b1;
        commit_rob_id = 5'd5;
        tick();
        enq_valid = 1'b0;
        commit_rob_id = 5'd6;
        tick();
        commit_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 32'h602) begin errors++; $display("FAIL bp_hold_addr[%0d] got v=%b a=%h exp v=1 a=602", c, dc_req_valid, dc_req_addr); end
            checks++; if (dc_req_data !== 32'hBEEF || dc_req_size !== 2'd1) begin errors++; $display("FAIL bp_hold_data[%0d] got d=%h s=%0d exp d=beef s=1", c, dc_req_data, dc_req_size); end
            checks++; if (count !== 4'd2) begin errors++; $display("FAIL bp_hold_count[%0d] got %0d exp 2", c, count); end
            tick();
        end
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        #1;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL bp_single_pop_count got %0d exp 1", count); end
        checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 32'h700) begin errors++; $display("FAIL bp_next_head got v=%b a=%h exp v=1 a=700", dc_req_valid, dc_req_addr); end
        drain();
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL bp_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_reset_mid();
        dc_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_enq(1'b1, 32'h800 + 32'(4 * i), 32'h8800 + 32'(i), 2'd2, 5'(20 + i));
            tick();
        end
        enq_valid = 1'b0;
        for (int r = 20; r <= 21; r++) begin
            commit_valid = 1'b1;
            commit_rob_id = 5'(r);
            tick();
        end
        commit_valid = 1'b0;
        #1;
        checks++; if (count !== 4'd4 || dc_req_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got c=%0d v=%b exp c=4 v=1", count, dc_req_valid); end
        rst_aL = 1'b0;
        dc_req_ready = 1'b1;
        set_enq(1'b1, 32'h900, 32'h99, 2'd2, 5'd30);
        tick();
        rst_aL = 1'b1;
        enq_valid = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", count); end
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dc_valid got %b exp 0", dc_req_valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL rstmid_enq_ready got %b exp 1", enq_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet[%0d] got %b exp 0", c, dc_req_valid); end
        end
    endtask

    task automatic test_random();
        logic [4:0]  rob_ctr;
        bit          e_hit, e_conf, rdy;
        logic [31:0] e_data, m;
        int          sz, fsz, oldest;
        rob_ctr = '0;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            sz = $urandom_range(0, 2);
            m = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
            set_enq($urandom_range(0, 99) < 60,
                    32'h300 + 32'($urandom_range(0, 3) * 4) +
                        ((sz == 0) ? 32'($urandom_range(0, 3)) : (sz == 1) ? 32'($urandom_range(0, 1) * 2) : 32'd0),
                    $urandom & m, 2'(sz), rob_ctr);
            oldest = -1;
            foreach (mq[i]) if (oldest < 0 && !mq[i].committed) oldest = i;
            commit_valid = 1'b0;
            commit_rob_id = rob_ctr + 5'd16;
            if ($urandom_range(0, 99) < 10) commit_valid = 1'b1;
            if (oldest >= 0 && $urandom_range(0, 99) < 50) begin
                commit_valid = 1'b1;
                commit_rob_id = mq[oldest].rob;
            end
            flush = ($urandom_range(0, 99) < 5);
            dc_req_ready = ($urandom_range(0, 99) < 50);
            fsz = $urandom_range(0, 2);
            fwd_size = 2'(fsz);
            fwd_addr = 32'h300 + 32'($urandom_range(0, 3) * 4) +
                       ((fsz == 0) ? 32'($urandom_range(0, 3)) : (fsz == 1) ? 32'($urandom_range(0, 1) * 2) : 32'd0);
            #1;
            rdy = (mq.size() < N) && !flush;
            model_fwd(fwd_addr, fwd_size, e_hit, e_conf, e_data);
            checks++; if (enq_ready !== rdy) begin errors++; $display("FAIL rnd_enq_ready c=%0d got %b exp %b", c, enq_ready, rdy); end
            checks++; if (count !== 4'(mq.size())) begin errors++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, count, mq.size()); end
            checks++; if (dc_req_valid !== (mq.size() > 0 && mq[0].committed)) begin errors++; $display("FAIL rnd_dc_valid c=%0d got %b", c, dc_req_valid); end
            if (mq.size() > 0 && mq[0].committed) begin
                checks++; if (dc_req_addr !== mq[0].addr || dc_req_size !== mq[0].size) begin errors++; $display("FAIL rnd_dc_req c=%0d got a=%h s=%0d exp a=%h s=%0d", c, dc_req_addr, dc_req_size, mq[0].addr, mq[0].size); end
                if (dc_req_ready) begin
                    checks++; if (exp_q.size() == 0 || dc_req_data !== exp_q[0]) begin errors++; $display("FAIL rnd_dc_data c=%0d got %h exp_q_size %0d", c, dc_req_data, exp_q.size()); end
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
            checks++; if (fwd_hit !== e_hit || fwd_conflict !== e_conf) begin errors++; $display("FAIL rnd_fwd_flags c=%0d a=%h s=%0d got %b%b exp %b%b", c, fwd_addr, fwd_size, fwd_hit, fwd_conflict, e_hit, e_conf); end
            checks++; if (fwd_data !== e_data) begin errors++; $display("FAIL rnd_fwd_data c=%0d got %h exp %h", c, fwd_data, e_data); end
            if (enq_valid && rdy) rob_ctr = rob_ctr + 5'd1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_full_wrap();
        test_forward();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
